// File: rtl/lagarto_plic_core_if.sv
// Claim/complete handshake and notification bundle between the PLIC core
// (slave) and the hart-context / bus front-end side (master).
interface lagarto_plic_core_if #(
    parameter int ID_WIDTH = 4
);
    logic                claim_i;
    logic                complete_i;
    logic [ID_WIDTH-1:0] complete_id_i;
    logic                interrupt_notification_o;
    logic [ID_WIDTH-1:0] interrupt_id_o;
    logic [ID_WIDTH-1:0] claim_id_o;
    logic                claim_valid_o;

    modport master (
        output claim_i, complete_i, complete_id_i,
        input  interrupt_notification_o, interrupt_id_o, claim_id_o, claim_valid_o
    );

    modport slave (
        input  claim_i, complete_i, complete_id_i,
        output interrupt_notification_o, interrupt_id_o, claim_id_o, claim_valid_o
    );
endinterface

// File: rtl/lagarto_plic_core.sv
// Lagarto PLIC core: per-source level/edge gateways, priority/threshold
// arbitration and the claim/complete handshake for a single hart context.
module lagarto_plic_core #(
    parameter int NUMBER_OF_INTERRUPT_SOURCES = 8,
    parameter int PRIORITY_WIDTH              = 3,
    parameter int ID_WIDTH                    = $clog2(NUMBER_OF_INTERRUPT_SOURCES + 1)
) (
    input  logic                                                  clk_i,
    input  logic                                                  rstn_i,
    input  logic [NUMBER_OF_INTERRUPT_SOURCES-1:0]                interrupt_signal_i,
    input  logic [NUMBER_OF_INTERRUPT_SOURCES-1:0]                edge_mode_i,
    input  logic [NUMBER_OF_INTERRUPT_SOURCES-1:0]                interrupt_enable_i,
    input  logic [NUMBER_OF_INTERRUPT_SOURCES*PRIORITY_WIDTH-1:0] interrupt_priority_i,
    input  logic [PRIORITY_WIDTH-1:0]                             priority_threshold_i,
    lagarto_plic_core_if.slave                                    plic_if
);
    localparam int N = NUMBER_OF_INTERRUPT_SOURCES;

    typedef enum logic [1:0] {
        GW_IDLE       = 2'd0,
        GW_PENDING    = 2'd1,
        GW_IN_SERVICE = 2'd2
    } gw_state_e;

    gw_state_e           state_q [N];
    gw_state_e           state_d [N];
    logic [N-1:0]        prev_sample_q, prev_sample_d;
    logic [N-1:0]        missed_edge_q, missed_edge_d;
    logic [ID_WIDTH-1:0] interrupt_id_q, interrupt_id_d;
    logic                notification_q, notification_d;
    logic [ID_WIDTH-1:0] claim_id_q, claim_id_d;
    logic                claim_valid_q, claim_valid_d;

    logic [N-1:0]              trigger;
    logic [N-1:0]              claim_hit;
    logic [N-1:0]              complete_hit;
    logic [ID_WIDTH-1:0]       best_id;
    logic [PRIORITY_WIDTH-1:0] best_prio;
    logic [PRIORITY_WIDTH-1:0] cur_prio;

    // Level sources trigger while high; edge sources only on a 0->1 transition.
    assign trigger = interrupt_signal_i & ~(edge_mode_i & prev_sample_q);

    // Gateway next-state: pend on trigger, go in service on claim, release on complete.
    always_comb begin
        prev_sample_d = interrupt_signal_i;
        missed_edge_d = missed_edge_q;
        claim_hit     = '0;
        complete_hit  = '0;
        for (int i = 0; i < N; i++) begin
            state_d[i]      = state_q[i];
            // interrupt_id_q is never 0 for a real source, so an empty claim hits nothing.
            claim_hit[i]    = plic_if.claim_i && (interrupt_id_q == ID_WIDTH'(i + 1));
            // IDs 0 and > N never match any index, so they are ignored naturally.
            complete_hit[i] = plic_if.complete_i && (plic_if.complete_id_i == ID_WIDTH'(i + 1));
            case (state_q[i])
                GW_IDLE: begin
                    if (trigger[i]) state_d[i] = GW_PENDING;
                end
                GW_PENDING: begin
                    if (claim_hit[i]) state_d[i] = GW_IN_SERVICE;
                    if (edge_mode_i[i] && trigger[i]) missed_edge_d[i] = 1'b1;
                end
                GW_IN_SERVICE: begin
                    if (complete_hit[i]) begin
                        // An edge remembered during service (or arriving now) re-pends at once.
                        if (missed_edge_q[i] || (edge_mode_i[i] && trigger[i])) begin
                            state_d[i]       = GW_PENDING;
                            missed_edge_d[i] = 1'b0;
                        end else begin
                            state_d[i] = GW_IDLE;
                        end
                    end else if (edge_mode_i[i] && trigger[i]) begin
                        missed_edge_d[i] = 1'b1;
                    end
                end
                default: state_d[i] = GW_IDLE;
            endcase
        end
    end

    // Arbitration: highest eligible priority wins, strict compare keeps the lowest ID on ties.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        cur_prio  = '0;
        for (int i = 0; i < N; i++) begin
            cur_prio = interrupt_priority_i[i*PRIORITY_WIDTH +: PRIORITY_WIDTH];
            // The source being claimed this cycle is masked so it cannot be returned twice.
            if ((state_q[i] == GW_PENDING) && interrupt_enable_i[i] && !claim_hit[i] &&
                (cur_prio != '0) && (cur_prio > priority_threshold_i) &&
                (cur_prio > best_prio)) begin
                best_prio = cur_prio;
                best_id   = ID_WIDTH'(i + 1);
            end
        end
    end

    // Output next-state: registered candidate and claim response.
    always_comb begin
        interrupt_id_d = best_id;
        notification_d = (best_id != '0);
        claim_valid_d  = plic_if.claim_i;
        claim_id_d     = plic_if.claim_i ? interrupt_id_q : claim_id_q;
    end

    // State register for gateways and outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < N; i++) state_q[i] <= GW_IDLE;
            prev_sample_q  <= '0;
            missed_edge_q  <= '0;
            interrupt_id_q <= '0;
            notification_q <= 1'b0;
            claim_id_q     <= '0;
            claim_valid_q  <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) state_q[i] <= state_d[i];
            prev_sample_q  <= prev_sample_d;
            missed_edge_q  <= missed_edge_d;
            interrupt_id_q <= interrupt_id_d;
            notification_q <= notification_d;
            claim_id_q     <= claim_id_d;
            claim_valid_q  <= claim_valid_d;
        end
    end

    assign plic_if.interrupt_notification_o = notification_q;
    assign plic_if.interrupt_id_o           = interrupt_id_q;
    assign plic_if.claim_id_o               = claim_id_q;
    assign plic_if.claim_valid_o            = claim_valid_q;
endmodule

// File: tb/tb_lagarto_plic_core.sv
// Directed bench for lagarto_plic_core: claim responses go through a
// scoreboard queue, candidate/notification values are checked inline.
module tb_lagarto_plic_core;
    localparam int N  = 8;
    localparam int PW = 3;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    sig = '0;
    logic [N-1:0]    edge_m = '0;
    logic [N-1:0]    en = '0;
    logic [N*PW-1:0] prio = '0;
    logic [PW-1:0]   thr = '0;

    int total  = 0;
    int passed = 0;
    logic [IW-1:0] claim_exp_q [$];

    lagarto_plic_core_if #(.ID_WIDTH(IW)) plic_if ();

    lagarto_plic_core #(
        .NUMBER_OF_INTERRUPT_SOURCES(N),
        .PRIORITY_WIDTH(PW)
    ) dut (
        .clk_i               (clk),
        .rstn_i              (rstn),
        .interrupt_signal_i  (sig),
        .edge_mode_i         (edge_m),
        .interrupt_enable_i  (en),
        .interrupt_priority_i(prio),
        .priority_threshold_i(thr),
        .plic_if             (plic_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_prio(input int src, input int val);
        prio[src*PW +: PW] = PW'(val);
    endtask

    task automatic do_claim(input logic [IW-1:0] exp_id);
        claim_exp_q.push_back(exp_id);
        plic_if.claim_i = 1'b1;
        tick();
        plic_if.claim_i = 1'b0;
    endtask

    task automatic do_complete(input logic [IW-1:0] id);
        plic_if.complete_i    = 1'b1;
        plic_if.complete_id_i = id;
        tick();
        plic_if.complete_i    = 1'b0;
        plic_if.complete_id_i = '0;
    endtask

    // Scoreboard: every claim_valid pulse pops and compares one expected claim ID.
    always @(negedge clk) begin
        if (plic_if.claim_valid_o === 1'b1) begin
            if (claim_exp_q.size() == 0) chk("claim_unexpected_valid", plic_if.claim_valid_o, 0);
            else chk("claim_id", plic_if.claim_id_o, claim_exp_q.pop_front());
        end
    end

    initial begin
        plic_if.claim_i       = 1'b0;
        plic_if.complete_i    = 1'b0;
        plic_if.complete_id_i = '0;
        tick(2);
        chk("rst_notif", plic_if.interrupt_notification_o, 0);
        chk("rst_id", plic_if.interrupt_id_o, 0);
        chk("rst_claim_id", plic_if.claim_id_o, 0);
        chk("rst_claim_valid", plic_if.claim_valid_o, 0);
        rstn = 1'b1;
        tick();

        // Level source 3 (ID 4): latency, claim, level re-pend after complete
        set_prio(3, 2); en[3] = 1'b1; sig[3] = 1'b1;
        tick();
        chk("lvl_lat1_id", plic_if.interrupt_id_o, 0);
        tick();
        chk("lvl_lat2_id", plic_if.interrupt_id_o, 4);
        chk("lvl_lat2_notif", plic_if.interrupt_notification_o, 1);
        do_claim(4);
        chk("lvl_claimed_notif", plic_if.interrupt_notification_o, 0);
        chk("lvl_claimed_id", plic_if.interrupt_id_o, 0);
        do_complete(4);
        tick();
        chk("lvl_repend_2", plic_if.interrupt_id_o, 0);
        tick();
        chk("lvl_repend_3", plic_if.interrupt_id_o, 4);
        do_claim(4);
        sig[3] = 1'b0;
        do_complete(4);
        en[3] = 1'b0;
        tick(2);

        // Equal priority tie: IDs 2 and 5
        set_prio(1, 3); set_prio(4, 3); en[1] = 1'b1; en[4] = 1'b1;
        sig[1] = 1'b1; sig[4] = 1'b1;
        tick(2);
        chk("tie_id", plic_if.interrupt_id_o, 2);
        do_claim(2);
        chk("tie_next_id", plic_if.interrupt_id_o, 5);
        do_claim(5);
        chk("tie_empty_id", plic_if.interrupt_id_o, 0);
        sig[1] = 1'b0; sig[4] = 1'b0;
        do_complete(2);
        do_complete(5);
        en[1] = 1'b0; en[4] = 1'b0;
        tick(2);

        // Threshold and priority 0
        set_prio(6, 1); en[6] = 1'b1; thr = 3'd1; sig[6] = 1'b1;
        tick(3);
        chk("thr_block_id", plic_if.interrupt_id_o, 0);
        thr = 3'd0;
        tick();
        chk("thr_lower_id", plic_if.interrupt_id_o, 7);
        do_claim(7);
        sig[6] = 1'b0;
        do_complete(7);
        en[6] = 1'b0;
        set_prio(7, 0); en[7] = 1'b1; sig[7] = 1'b1;
        tick(3);
        chk("prio0_id", plic_if.interrupt_id_o, 0);
        chk("prio0_notif", plic_if.interrupt_notification_o, 0);
        set_prio(7, 5);
        tick();
        chk("prio_raise_id", plic_if.interrupt_id_o, 8);
        do_claim(8);
        sig[7] = 1'b0;
        do_complete(8);
        en[7] = 1'b0;
        tick(2);

        // Edge source 2 (ID 3): one remembered edge during service
        edge_m[2] = 1'b1; set_prio(2, 4); en[2] = 1'b1;
        sig[2] = 1'b1; tick(); sig[2] = 1'b0;
        tick();
        chk("edge_id", plic_if.interrupt_id_o, 3);
        do_claim(3);
        sig[2] = 1'b1; tick(); sig[2] = 1'b0; tick();
        sig[2] = 1'b1; tick(); sig[2] = 1'b0; tick();
        chk("edge_insvc_id", plic_if.interrupt_id_o, 0);
        do_complete(3);
        chk("edge_cmp1_id", plic_if.interrupt_id_o, 0);
        tick();
        chk("edge_repend_id", plic_if.interrupt_id_o, 3);
        do_claim(3);
        do_complete(3);
        tick(3);
        chk("edge_idle_id", plic_if.interrupt_id_o, 0);
        chk("edge_idle_notif", plic_if.interrupt_notification_o, 0);
        en[2] = 1'b0;

        // Empty claim and ignored completes
        do_claim(0);
        chk("empty_claim_notif", plic_if.interrupt_notification_o, 0);
        set_prio(5, 2); en[5] = 1'b1; sig[5] = 1'b1;
        tick(2);
        chk("svc_src_id", plic_if.interrupt_id_o, 6);
        do_claim(6);
        do_complete(0);
        tick(2);
        chk("cmp_id0_ignored", plic_if.interrupt_id_o, 0);
        do_complete(9);
        tick(2);
        chk("cmp_idN1_ignored", plic_if.interrupt_id_o, 0);
        do_complete(4);
        tick(2);
        chk("cmp_unclaimed_ignored", plic_if.interrupt_id_o, 0);

        // Reset with ID 6 in service and ID 2 pending
        set_prio(1, 1); en[1] = 1'b1; sig[1] = 1'b1;
        tick(2);
        chk("pre_rst_id", plic_if.interrupt_id_o, 2);
        rstn = 1'b0;
        #1;
        chk("async_rst_notif", plic_if.interrupt_notification_o, 0);
        chk("async_rst_id", plic_if.interrupt_id_o, 0);
        chk("async_rst_claim_id", plic_if.claim_id_o, 0);
        chk("async_rst_claim_valid", plic_if.claim_valid_o, 0);
        tick(2);
        rstn = 1'b1;
        tick();
        chk("post_rst_1_id", plic_if.interrupt_id_o, 0);
        tick();
        chk("post_rst_2_id", plic_if.interrupt_id_o, 6);
        tick(2);
        chk("scoreboard_drained", claim_exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
